// File: rtl/wb_port_arb_ysyx23060136_pkg.sv
// Shared definitions for the GPR write-port arbiter: register index width and arbiter states.
package DEFINES_ysyx23060136;
   localparam int GPR_IDX_W = 5;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HELD   = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } arb_state_t;
endpackage

// File: rtl/wb_port_arb_ysyx23060136.sv
// Shares the GPR write port between WB (zero latency) and a one-entry MDU result buffer.
// MDU writes land 1..STARVE_LIMIT+1 cycles after acceptance; WB is stalled one cycle when the buffer starves.
module wb_port_arb_ysyx23060136
   import DEFINES_ysyx23060136::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_i_valid,
   input  logic                 pipe_i_write_gpr,
   input  logic [GPR_IDX_W-1:0] pipe_i_rd,
   input  logic [31:0]          pipe_i_data,
   input  logic                 pipe_i_system_halt,
   output logic                 pipe_o_stall,
   input  logic                 mdu_i_valid,
   input  logic [GPR_IDX_W-1:0] mdu_i_rd,
   input  logic [31:0]          mdu_i_data,
   output logic                 mdu_o_ready,
   output logic                 rf_o_wen,
   output logic [GPR_IDX_W-1:0] rf_o_rd,
   output logic [31:0]          rf_o_busW,
   output logic                 arb_o_pending,
   output logic [GPR_IDX_W-1:0] arb_o_pending_rd,
   output logic                 arb_o_halt
);

   arb_state_t           state;
   logic [CNT_W-1:0]     cnt;
   logic [GPR_IDX_W-1:0] buf_rd;
   logic [31:0]          buf_data;

   logic                 pipe_want, force_buf, pipe_wr, buf_wr, waw_drop;
   logic                 stall, ready, wen, mdu_keep, halt_go, buf_vld, nxt_vld;
   logic [GPR_IDX_W-1:0] wrd;
   logic [31:0]          wdata;

   assign buf_vld = (state == HELD) || (state == DRAIN);

   always_comb begin
      pipe_want = pipe_i_valid && pipe_i_write_gpr && (pipe_i_rd != '0);
      force_buf = 1'b0;
      pipe_wr   = 1'b0;
      buf_wr    = 1'b0;
      waw_drop  = 1'b0;
      stall     = 1'b0;
      ready     = 1'b0;
      wen       = 1'b0;
      wrd       = '0;
      wdata     = '0;
      case (state)
         EMPTY, HELD: begin
            force_buf = (state == HELD) && (cnt == CNT_W'(STARVE_LIMIT)) && pipe_want;
            if (force_buf) begin
               stall  = 1'b1;
               wen    = 1'b1;
               wrd    = buf_rd;
               wdata  = buf_data;
               buf_wr = 1'b1;
            end else if (pipe_want) begin
               pipe_wr = 1'b1;
               wen     = 1'b1;
               wrd     = pipe_i_rd;
               wdata   = pipe_i_data;
               // the committing instruction is younger, so its write supersedes the buffered one
               waw_drop = (state == HELD) && (pipe_i_rd == buf_rd);
            end else if (state == HELD) begin
               wen    = 1'b1;
               wrd    = buf_rd;
               wdata  = buf_data;
               buf_wr = 1'b1;
            end
            ready = (state == EMPTY) || buf_wr || waw_drop;
         end
         DRAIN: begin
            stall  = 1'b1;
            wen    = 1'b1;
            wrd    = buf_rd;
            wdata  = buf_data;
            buf_wr = 1'b1;
         end
         default: stall = 1'b1;
      endcase
      mdu_keep = mdu_i_valid && ready && (mdu_i_rd != '0) &&
                 !(pipe_wr && (pipe_i_rd == mdu_i_rd));
      halt_go  = pipe_i_valid && pipe_i_system_halt && !stall;
      nxt_vld  = mdu_keep || (buf_vld && !buf_wr && !waw_drop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         cnt      <= '0;
         buf_rd   <= '0;
         buf_data <= '0;
      end else begin
         if (mdu_keep) begin
            buf_rd   <= mdu_i_rd;
            buf_data <= mdu_i_data;
         end
         case (state)
            EMPTY, HELD: begin
               if (halt_go) state <= nxt_vld ? DRAIN : HALTED;
               else         state <= nxt_vld ? HELD  : EMPTY;
            end
            default: state <= HALTED;
         endcase
         if (!nxt_vld || buf_wr || waw_drop)
            cnt <= '0;
         else if ((state == HELD) && (cnt != CNT_W'(STARVE_LIMIT)))
            cnt <= cnt + CNT_W'(1);
      end
   end

   // outputs show reset values while rst is held, whatever the registered state
   assign pipe_o_stall     = !rst && stall;
   assign mdu_o_ready      = rst || ready;
   assign rf_o_wen         = !rst && wen;
   assign rf_o_rd          = rst ? '0 : wrd;
   assign rf_o_busW        = rst ? '0 : wdata;
   assign arb_o_pending    = !rst && buf_vld;
   assign arb_o_pending_rd = arb_o_pending ? buf_rd : '0;
   assign arb_o_halt       = !rst && (state == HALTED);

endmodule

// File: tb/tb_wb_port_arb_ysyx23060136.sv
// Vector table plus starvation-bound sequence for the GPR write-port arbiter.
module tb_wb_port_arb_ysyx23060136;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic        rst, pv, wg;
      logic [4:0]  prd;
      logic [31:0] pdata;
      logic        phalt, mv;
      logic [4:0]  mrd;
      logic [31:0] mdata;
   } in_t;

   typedef struct packed {
      logic        stall, ready, wen;
      logic [4:0]  rd;
      logic [31:0] bus;
      logic        pend;
      logic [4:0]  prd;
      logic        halt;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic        clk, rst;
   logic        pipe_i_valid, pipe_i_write_gpr, pipe_i_system_halt, pipe_o_stall;
   logic [4:0]  pipe_i_rd, mdu_i_rd, rf_o_rd, arb_o_pending_rd;
   logic [31:0] pipe_i_data, mdu_i_data, rf_o_busW;
   logic        mdu_i_valid, mdu_o_ready, rf_o_wen, arb_o_pending, arb_o_halt;

   wb_port_arb_ysyx23060136 #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_i_valid(pipe_i_valid), .pipe_i_write_gpr(pipe_i_write_gpr),
      .pipe_i_rd(pipe_i_rd), .pipe_i_data(pipe_i_data),
      .pipe_i_system_halt(pipe_i_system_halt), .pipe_o_stall(pipe_o_stall),
      .mdu_i_valid(mdu_i_valid), .mdu_i_rd(mdu_i_rd), .mdu_i_data(mdu_i_data),
      .mdu_o_ready(mdu_o_ready),
      .rf_o_wen(rf_o_wen), .rf_o_rd(rf_o_rd), .rf_o_busW(rf_o_busW),
      .arb_o_pending(arb_o_pending), .arb_o_pending_rd(arb_o_pending_rd),
      .arb_o_halt(arb_o_halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec  = 0;
   int   n_miss = 0;
   vec_t vecs[$];
   out_t sb[$];

   function automatic in_t mk_in(input logic r, input logic pv, input logic wg,
                                 input logic [4:0] prd, input logic [31:0] pd,
                                 input logic ph, input logic mv,
                                 input logic [4:0] mrd, input logic [31:0] md);
      in_t t;
      t.rst = r; t.pv = pv; t.wg = wg; t.prd = prd; t.pdata = pd;
      t.phalt = ph; t.mv = mv; t.mrd = mrd; t.mdata = md;
      return t;
   endfunction

   function automatic out_t mk_out(input logic st, input logic rdy, input logic w,
                                   input logic [4:0] rd, input logic [31:0] bus,
                                   input logic pend, input logic [4:0] prd,
                                   input logic h);
      out_t t;
      t.stall = st; t.ready = rdy; t.wen = w; t.rd = rd; t.bus = bus;
      t.pend = pend; t.prd = prd; t.halt = h;
      return t;
   endfunction

   // shorthand stimulus: pipeline GPR write, MDU offer, idle
   function automatic in_t pw(input logic [4:0] rd, input logic [31:0] d);
      return mk_in(0, 1, 1, rd, d, 0, 0, 0, 0);
   endfunction
   function automatic in_t mo(input logic [4:0] rd, input logic [31:0] d);
      return mk_in(0, 0, 0, 0, 0, 0, 1, rd, d);
   endfunction

   task automatic add(input in_t i, input out_t o);
      vec_t v;
      v.i = i; v.o = o;
      vecs.push_back(v);
   endtask

   task automatic drive(input in_t i);
      rst = i.rst; pipe_i_valid = i.pv; pipe_i_write_gpr = i.wg;
      pipe_i_rd = i.prd; pipe_i_data = i.pdata; pipe_i_system_halt = i.phalt;
      mdu_i_valid = i.mv; mdu_i_rd = i.mrd; mdu_i_data = i.mdata;
   endtask

   function automatic out_t sample();
      return mk_out(pipe_o_stall, mdu_o_ready, rf_o_wen, rf_o_rd, rf_o_busW,
                    arb_o_pending, arb_o_pending_rd, arb_o_halt);
   endfunction

   task automatic check(input string name, input out_t got, input out_t exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got stall=%b rdy=%b wen=%b rd=%0d bus=%h pend=%b prd=%0d halt=%b, want stall=%b rdy=%b wen=%b rd=%0d bus=%h pend=%b prd=%0d halt=%b",
                  name, got.stall, got.ready, got.wen, got.rd, got.bus, got.pend, got.prd, got.halt,
                  exp.stall, exp.ready, exp.wen, exp.rd, exp.bus, exp.pend, exp.prd, exp.halt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      in_t  n;
      out_t o_idle, o_halted, got, exp;
      int   lat;
      bit   found;

      n        = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      o_idle   = mk_out(0, 1, 0, 0, 0, 0, 0, 0);
      o_halted = mk_out(1, 0, 0, 0, 0, 0, 0, 1);
      drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0));

      // reset, including reset with active inputs
      add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0), o_idle);
      add(mk_in(1, 1, 1, 3, 32'h33, 0, 1, 4, 32'h44), o_idle);
      add(n, o_idle);
      // MDU only
      add(mo(5, 32'h1234), o_idle);
      add(n, mk_out(0, 1, 1, 5, 32'h1234, 1, 5, 0));
      add(n, o_idle);
      // contention: buffer rd=7 starved by 4 pipeline writes
      add(mo(7, 32'h77), o_idle);
      add(pw(3, 32'h33), mk_out(0, 0, 1, 3, 32'h33, 1, 7, 0));
      add(pw(4, 32'h44), mk_out(0, 0, 1, 4, 32'h44, 1, 7, 0));
      add(pw(5, 32'h55), mk_out(0, 0, 1, 5, 32'h55, 1, 7, 0));
      add(pw(6, 32'h66), mk_out(0, 0, 1, 6, 32'h66, 1, 7, 0));
      add(pw(8, 32'h88), mk_out(1, 1, 1, 7, 32'h77, 1, 7, 0));
      add(pw(8, 32'h88), mk_out(0, 1, 1, 8, 32'h88, 0, 0, 0));
      // WAW drop against the buffer
      add(mo(9, 32'h99), o_idle);
      add(pw(9, 32'hAA), mk_out(0, 1, 1, 9, 32'hAA, 1, 9, 0));
      add(n, o_idle);
      add(n, o_idle);
      // zero register and non-writing instruction
      add(mk_in(0, 1, 1, 0, 32'hBB, 0, 1, 0, 32'h5), o_idle);
      add(n, o_idle);
      add(mk_in(0, 1, 0, 4, 32'hCC, 0, 0, 0, 0), o_idle);
      // same-cycle WAW: MDU result with pipeline's rd is accepted and discarded
      add(mk_in(0, 1, 1, 6, 32'h61, 0, 1, 6, 32'h62), mk_out(0, 1, 1, 6, 32'h61, 0, 0, 0));
      add(n, o_idle);
      // refill in the cycle the buffer is written
      add(mo(10, 32'hA0), o_idle);
      add(mo(11, 32'hB0), mk_out(0, 1, 1, 10, 32'hA0, 1, 10, 0));
      add(n, mk_out(0, 1, 1, 11, 32'hB0, 1, 11, 0));
      add(n, o_idle);
      // halt with buffer held: drain then halted, sticky
      add(mo(2, 32'h22), o_idle);
      add(mk_in(0, 1, 1, 12, 32'hC0, 1, 0, 0, 0), mk_out(0, 0, 1, 12, 32'hC0, 1, 2, 0));
      add(mo(13, 32'hD0), mk_out(1, 0, 1, 2, 32'h22, 1, 2, 0));
      add(mk_in(0, 1, 1, 14, 32'hE0, 0, 1, 13, 32'hD0), o_halted);
      add(n, o_halted);
      add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0), o_idle);
      add(n, o_idle);
      // halt with empty buffer goes straight to halted
      add(mk_in(0, 1, 0, 0, 0, 1, 0, 0, 0), o_idle);
      add(n, o_halted);
      add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0), o_idle);
      // reset while HELD discards the buffer
      add(mo(15, 32'hF0), o_idle);
      add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0), o_idle);
      add(n, o_idle);
      add(n, o_idle);

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].i);
         sb.push_back(vecs[k].o);
         #1;
         got = sample();
         exp = sb.pop_front();
         check($sformatf("vec%0d", k), got, exp);
      end

      // starvation bound: continuous pipeline traffic, MDU write must be forced at LIMIT+1
      @(negedge clk);
      drive(mo(20, 32'hDEAD));
      #1;
      check("starve_accept", sample(), o_idle);
      found = 0;
      lat   = 0;
      for (int k = 0; k <= LIMIT && !found; k++) begin
         @(negedge clk);
         drive(pw(5'(21 + k), 32'h100 + 32'(k)));
         #1;
         lat = k + 1;
         if (rf_o_wen && rf_o_rd == 5'd20) found = 1;
      end
      n_vec++;
      if (!found || lat != LIMIT + 1 || !pipe_o_stall || rf_o_busW !== 32'hDEAD) begin
         n_miss++;
         $display("FAIL starve_bound: found=%0d latency=%0d stall=%b bus=%h, want found=1 latency=%0d stall=1 bus=dead",
                  found, lat, pipe_o_stall, rf_o_busW, LIMIT + 1);
      end
      @(negedge clk);
      drive(n);
      #1;
      check("starve_after", sample(), o_idle);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
